// File: rtl/clock_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clock_reset_sequencer
// Brief    : PLL reset pulse, lock qualification and staged reset release
// Revision : 1.0 - initial release
// ============================================================================
module clock_reset_sequencer #(
  parameter int N_RST        = 2,
  parameter int RST_PULSE_W  = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int STAGE_DLY    = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             pll_locked_i,
  input  logic             soft_rst_i,
  output logic             pll_rst_o,
  output logic [N_RST-1:0] rst_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic             lock_lost_o,
  output logic [((MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)) - 1:0] retry_cnt_o
);

  localparam int c_retry_w   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int c_max_ab    = (RST_PULSE_W > LOCK_STABLE) ? RST_PULSE_W : LOCK_STABLE;
  localparam int c_max_cd    = (STAGE_DLY > LOCK_TIMEOUT) ? STAGE_DLY : LOCK_TIMEOUT;
  localparam int c_cnt_max   = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cnt_w     = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0]   c_pulse_last   = c_cnt_w'(RST_PULSE_W - 1);
  localparam logic [c_cnt_w-1:0]   c_stable_last  = c_cnt_w'(LOCK_STABLE - 1);
  localparam logic [c_cnt_w-1:0]   c_stage_last   = c_cnt_w'(STAGE_DLY - 1);
  localparam logic [c_cnt_w-1:0]   c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_retry_w-1:0] c_max_retry    = c_retry_w'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_retry_w-1:0]   r_retry_cnt;
  logic [N_RST-1:0]       r_rst;
  logic                   r_pll_rst;
  logic                   r_ready;
  logic                   r_fail;
  logic                   r_lock_lost;
  logic                   r_sync_meta;
  logic                   r_locked_s;
  logic                   r_soft_q;
  logic                   r_soft_edge;

  logic                   w_lock_loss;
  logic [N_RST-1:0]       w_rst_shift;

  // Released bits form a thermometer from bit 0 upward, so release is a left shift.
  assign w_rst_shift = r_rst << 1;
  assign w_lock_loss = ((r_state == ST_RELEASE) || (r_state == ST_RUN)) && !r_locked_s;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_sync_meta <= 1'b0;
      r_locked_s  <= 1'b0;
      r_soft_q    <= 1'b0;
      r_soft_edge <= 1'b0;
    end else begin
      r_sync_meta <= pll_locked_i;
      r_locked_s  <= r_sync_meta;
      r_soft_q    <= soft_rst_i;
      r_soft_edge <= soft_rst_i & ~r_soft_q;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_rst       <= '1;
      r_pll_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_lock_lost <= 1'b0;
    end else if (r_soft_edge) begin
      // Software request outranks lock loss, but a coincident loss is still recorded.
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_rst       <= '1;
      r_pll_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      if (w_lock_loss) r_lock_lost <= 1'b1;
    end else if (w_lock_loss) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_rst       <= '1;
      r_pll_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b1;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == c_pulse_last) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_locked_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_timeout_last) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_retry_cnt < c_max_retry) begin
              r_state     <= ST_PLL_RST;
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end else begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!r_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == c_stable_last) begin
            r_cnt <= '0;
            r_rst <= w_rst_shift;
            if (w_rst_shift == '0) begin
              r_state     <= ST_RUN;
              r_ready     <= 1'b1;
              r_retry_cnt <= '0;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == c_stage_last) begin
            r_cnt <= '0;
            r_rst <= w_rst_shift;
            if (w_rst_shift == '0) begin
              r_state     <= ST_RUN;
              r_ready     <= 1'b1;
              r_retry_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= '0;
        end
        ST_FAIL: begin
          r_pll_rst <= 1'b1;
          r_rst     <= '1;
          r_fail    <= 1'b1;
        end
        default: begin
          r_state   <= ST_PLL_RST;
          r_cnt     <= '0;
          r_rst     <= '1;
          r_pll_rst <= 1'b1;
          r_ready   <= 1'b0;
          r_fail    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst_o   = r_pll_rst;
  assign rst_o       = r_rst;
  assign ready_o     = r_ready;
  assign fail_o      = r_fail;
  assign lock_lost_o = r_lock_lost;
  assign retry_cnt_o = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clock_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_reset_sequencer
// Brief    : Directed self-checking bench for clock_reset_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_reset_sequencer;

  logic       r_clk;
  logic       r_arst;
  logic       r_locked;
  logic       r_soft;
  logic       w_pll_rst;
  logic [1:0] w_rst;
  logic       w_ready;
  logic       w_fail;
  logic       w_lock_lost;
  logic [1:0] w_retry_cnt;

  int n_cmp;
  int n_fail;

  clock_reset_sequencer #(
    .N_RST        (2),
    .RST_PULSE_W  (16),
    .LOCK_STABLE  (64),
    .STAGE_DLY    (8),
    .LOCK_TIMEOUT (32),
    .MAX_RETRY    (3)
  ) u_dut (
    .clk_i        (r_clk),
    .arst_i       (r_arst),
    .pll_locked_i (r_locked),
    .soft_rst_i   (r_soft),
    .pll_rst_o    (w_pll_rst),
    .rst_o        (w_rst),
    .ready_o      (w_ready),
    .fail_o       (w_fail),
    .lock_lost_o  (w_lock_lost),
    .retry_cnt_o  (w_retry_cnt)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    r_arst   = 1'b1;
    r_locked = 1'b0;
    r_soft   = 1'b0;
    #1;
    chk("rst_pll_rst",   w_pll_rst,   1);
    chk("rst_rst",       w_rst,       2'b11);
    chk("rst_ready",     w_ready,     0);
    chk("rst_fail",      w_fail,      0);
    chk("rst_lock_lost", w_lock_lost, 0);
    chk("rst_retry",     w_retry_cnt, 0);

    // Pulse after arst release lasts exactly 16 edges
    tick();
    r_arst = 1'b0;
    repeat (15) tick();
    chk("por_pulse_hi", w_pll_rst, 1);
    tick();
    chk("por_pulse_lo", w_pll_rst, 0);

    // Nominal: lock 20 cycles after pll_rst falls
    repeat (20) tick();
    r_locked = 1'b1;
    repeat (66) tick();
    chk("nom_rst_before", w_rst, 2'b11);
    tick();
    chk("nom_rst0_fall", w_rst, 2'b10);
    chk("nom_ready_early", w_ready, 0);
    chk("nom_retry", w_retry_cnt, 0);
    repeat (7) tick();
    chk("nom_rst1_held", w_rst, 2'b10);
    chk("nom_ready_held", w_ready, 0);
    tick();
    chk("nom_rst_all", w_rst, 2'b00);
    chk("nom_ready", w_ready, 1);
    chk("nom_retry_end", w_retry_cnt, 0);
    chk("nom_lock_lost", w_lock_lost, 0);

    // Lock loss in RUN
    r_locked = 1'b0;
    tick();
    tick();
    chk("ll_ready_still", w_ready, 1);
    chk("ll_rst_still", w_rst, 2'b00);
    tick();
    chk("ll_rst", w_rst, 2'b11);
    chk("ll_ready", w_ready, 0);
    chk("ll_sticky", w_lock_lost, 1);
    chk("ll_pll_rst", w_pll_rst, 1);
    repeat (15) tick();
    chk("ll_pulse_hi", w_pll_rst, 1);
    tick();
    chk("ll_pulse_lo", w_pll_rst, 0);
    r_locked = 1'b1;
    repeat (67) tick();
    chk("ll_rst0_fall", w_rst, 2'b10);
    repeat (8) tick();
    chk("ll_ready_back", w_ready, 1);
    chk("ll_rst_back", w_rst, 2'b00);
    chk("ll_still_sticky", w_lock_lost, 1);

    // soft_rst_i held high in RUN: one re-sequence only
    r_soft = 1'b1;
    tick();
    chk("sh_edge_lat", w_pll_rst, 0);
    tick();
    chk("sh_pll_rst", w_pll_rst, 1);
    chk("sh_ready", w_ready, 0);
    chk("sh_rst", w_rst, 2'b11);
    chk("sh_lock_lost", w_lock_lost, 1);
    repeat (16) tick();
    chk("sh_pulse_lo", w_pll_rst, 0);
    repeat (64) tick();
    chk("sh_rst_before", w_rst, 2'b11);
    tick();
    chk("sh_rst0_fall", w_rst, 2'b10);
    repeat (8) tick();
    chk("sh_ready_back", w_ready, 1);
    repeat (409) tick();
    chk("sh_no_second_ready", w_ready, 1);
    chk("sh_no_second_pll", w_pll_rst, 0);
    r_soft = 1'b0;
    tick();

    // Lock glitch in STABLE restarts the stable count
    r_soft   = 1'b1;
    r_locked = 1'b0;
    tick();
    tick();
    chk("gl_pll_rst", w_pll_rst, 1);
    r_soft = 1'b0;
    repeat (16) tick();
    chk("gl_pulse_lo", w_pll_rst, 0);
    r_locked = 1'b1;
    repeat (30) tick();
    r_locked = 1'b0;
    tick();
    r_locked = 1'b1;
    repeat (36) tick();
    chk("gl_no_early_release", w_rst, 2'b11);
    repeat (30) tick();
    chk("gl_rst_before", w_rst, 2'b11);
    tick();
    chk("gl_rst0_fall", w_rst, 2'b10);
    repeat (8) tick();
    chk("gl_ready", w_ready, 1);

    // Timeout, retries and FAIL
    r_soft   = 1'b1;
    r_locked = 1'b0;
    tick();
    tick();
    chk("to_pll_rst", w_pll_rst, 1);
    r_soft = 1'b0;
    repeat (16) tick();
    chk("to_pulse0_lo", w_pll_rst, 0);
    for (int r = 1; r <= 3; r++) begin
      repeat (31) tick();
      chk("to_wait_pll", w_pll_rst, 0);
      chk("to_wait_retry", w_retry_cnt, 32'(r - 1));
      tick();
      chk("to_retry_pll", w_pll_rst, 1);
      chk("to_retry_cnt", w_retry_cnt, 32'(r));
      chk("to_retry_fail", w_fail, 0);
      repeat (15) tick();
      chk("to_pulse_hi", w_pll_rst, 1);
      tick();
      chk("to_pulse_lo", w_pll_rst, 0);
    end
    repeat (31) tick();
    chk("to_fail_early", w_fail, 0);
    tick();
    chk("to_fail", w_fail, 1);
    chk("to_fail_pll", w_pll_rst, 1);
    chk("to_fail_retry", w_retry_cnt, 3);
    chk("to_fail_rst", w_rst, 2'b11);
    repeat (50) tick();
    chk("to_fail_hold", w_fail, 1);
    chk("to_fail_hold_pll", w_pll_rst, 1);
    r_soft = 1'b1;
    tick();
    tick();
    chk("to_soft_fail", w_fail, 0);
    chk("to_soft_retry", w_retry_cnt, 0);
    chk("to_soft_pll", w_pll_rst, 1);
    r_soft = 1'b0;
    repeat (16) tick();
    chk("to_soft_pulse_lo", w_pll_rst, 0);
    r_locked = 1'b1;
    repeat (75) tick();
    chk("to_recover_ready", w_ready, 1);
    chk("to_recover_rst", w_rst, 2'b00);

    // arst_i mid-RELEASE
    r_soft = 1'b1;
    tick();
    tick();
    r_soft = 1'b0;
    repeat (81) tick();
    chk("ar_rst0_fall", w_rst, 2'b10);
    chk("ar_lock_lost_pre", w_lock_lost, 1);
    #2;
    r_arst = 1'b1;
    #1;
    chk("ar_rst", w_rst, 2'b11);
    chk("ar_pll_rst", w_pll_rst, 1);
    chk("ar_lock_lost", w_lock_lost, 0);
    chk("ar_ready", w_ready, 0);
    tick();
    r_arst = 1'b0;
    repeat (15) tick();
    chk("ar_pulse_hi", w_pll_rst, 1);
    tick();
    chk("ar_pulse_lo", w_pll_rst, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Parametrised PLL reset and lock sequencer that sits beside a clock wizard PLL in each FPGA target and replaces the bare `~LOCKED` reset. It issues a minimum-width PLL reset pulse and requires LOCKED to be stable before releasing reset. It then releases `N_RST` reset outputs in staged order. It also handles lock timeouts with bounded retries, re-sequences on lock loss, and accepts a software re-sequence request.

## Interface
- `N_RST`, 2: number of staged reset outputs; must be ≥1.
- `RST_PULSE_W`, 16: cycles `pll_rst_o` is held high per PLL reset; must be ≥1.
- `LOCK_STABLE`, 64: consecutive synchronised-locked cycles required before release; must be ≥1.
- `STAGE_DLY`, 8: cycles between successive `rst_o` bit releases; must be ≥1.
- `LOCK_TIMEOUT`, 4096: cycles spent in WAIT_LOCK before a retry; must be ≥1.
- `MAX_RETRY`, 3: retries allowed before FAIL.

Ports:
- `clk_i` in 1: free-running reference clock, not the PLL output.
- `arst_i` in 1: asynchronous, active-high reset.
- `pll_locked_i` in 1: PLL LOCKED, asynchronous; passed through an internal 2-FF synchroniser to form `locked_s`.
- `soft_rst_i` in 1: re-sequence request, level input; rising-edge detected.
- `pll_rst_o` out 1: PLL RST.
- `rst_o` out `N_RST`: active-high resets, registered in `clk_i`; bit 0 is released first. Consumers resynchronise these into their own domains.
- `ready_o` out 1: high only in RUN.
- `fail_o` out 1: high only in FAIL.
- `lock_lost_o` out 1: sticky; set on lock loss in RELEASE or RUN.
- `retry_cnt_o` out `$clog2(MAX_RETRY+1)` (min 1): timeout retries in the current sequence.

## Operation
- All outputs are registered.
- Reset values: `pll_rst_o`=1, `rst_o`=all ones, `ready_o`=0, `fail_o`=0, `lock_lost_o`=0, `retry_cnt_o`=0, state PLL_RST, counters 0, synchroniser 0.
- **PLL_RST:** `pll_rst_o`=1 and `rst_o` all ones. After `RST_PULSE_W` cycles, go to WAIT_LOCK with `pll_rst_o`=0.
- **WAIT_LOCK:**
  - `locked_s`=1 → STABLE, counter cleared.
  - `LOCK_TIMEOUT` cycles without lock, and `retry_cnt`<`MAX_RETRY` → increment `retry_cnt`, go to PLL_RST.
  - `LOCK_TIMEOUT` cycles without lock, and `retry_cnt`=`MAX_RETRY` → FAIL.
- **STABLE:**
  - `locked_s`=0 → WAIT_LOCK; the timeout counter restarts from 0.
  - `LOCK_STABLE` consecutive cycles with `locked_s`=1 → RELEASE.
- **RELEASE:**
  - `rst_o[0]` clears on entry.
  - `rst_o[k]` clears `STAGE_DLY` cycles after `rst_o[k-1]`.
  - On the cycle `rst_o[N_RST-1]` clears: go to RUN, `ready_o`=1, `retry_cnt` cleared.
  - With `N_RST`=1, RUN is entered with `rst_o[0]` clearing.
- **RUN:** hold until lock loss or a soft request.
- **Lock loss** (`locked_s`=0 in RELEASE or RUN):
  - Next edge: `rst_o` all ones, `ready_o`=0, `lock_lost_o`=1, `pll_rst_o`=1.
  - Go to PLL_RST; `retry_cnt` is unchanged.
- **FAIL:** `pll_rst_o`=1 (PLL held in reset), `rst_o` all ones, `fail_o`=1. Exit only via `arst_i` or a `soft_rst_i` edge.
- **`soft_rst_i` rising edge, any state:**
  - Go to PLL_RST with `rst_o` all ones, `ready_o`=0, `fail_o`=0, `retry_cnt` cleared.
  - `lock_lost_o` is unchanged; only `arst_i` clears it.
  - A soft request has priority over lock loss and timeout in the same cycle. A simultaneous lock loss still sets `lock_lost_o`.
  - A held-high `soft_rst_i` produces exactly one re-sequence.
- `arst_i` at any point forces the reset values asynchronously. This includes mid-RELEASE, where already-released bits reassert immediately.

## Timing
- `pll_locked_i` to `locked_s` latency: 2 cycles.
- Lock-loss latency, `pll_locked_i` falling to `rst_o` all ones and `ready_o`=0: 3 cycles.
- After `arst_i` deasserts, `pll_rst_o` stays high for exactly `RST_PULSE_W` rising edges.
- `locked_s` rising in WAIT_LOCK → `rst_o[0]` clears `LOCK_STABLE`+1 cycles later.
- `rst_o[0]` clearing → `ready_o` rising: `(N_RST-1)*STAGE_DLY` cycles.
- `soft_rst_i` rising edge → `pll_rst_o`=1: 2 cycles (1 edge-detect register + 1 output register).
- Bits of `rst_o` never deassert out of order.
- All `rst_o` bits reassert in the same cycle.

## Test plan
- **Nominal, defaults:** `pll_locked_i` rises 20 cycles after `pll_rst_o` falls and stays high.
  - `rst_o[0]` falls 67 cycles after the lock edge (2 sync + `LOCK_STABLE`+1).
  - `rst_o[1]` falls with `ready_o`=1 exactly 8 cycles after that.
  - `retry_cnt_o`=0 throughout.
- **Lock glitch in STABLE:** lock high 30 cycles, low 1 cycle, high again.
  - Stable count restarts.
  - `rst_o[0]` falls 65 cycles after `locked_s` re-rises, not earlier.
- **Timeout and FAIL:** `LOCK_TIMEOUT`=32, lock never asserted.
  - Four `pll_rst_o` pulses of 16 cycles each.
  - `retry_cnt_o` steps 1, 2, 3.
  - Then `fail_o`=1 with `pll_rst_o` held 1.
  - A `soft_rst_i` edge clears `fail_o` and `retry_cnt_o`, and a lock then completes the sequence.
- **Lock loss in RUN:** drop `pll_locked_i`.
  - 3 cycles later `rst_o`=2'b11, `ready_o`=0, `lock_lost_o`=1, and a 16-cycle `pll_rst_o` pulse starts.
  - After re-lock, the sequence completes and `lock_lost_o` is still 1.
- **`arst_i` mid-RELEASE:** assert after `rst_o[0]` clears.
  - `rst_o`=2'b11 and `pll_rst_o`=1 before the next clock edge.
  - `lock_lost_o` is cleared.
- **`soft_rst_i` held high for 500 cycles in RUN:** exactly one re-sequence occurs, and `ready_o` returns high while `soft_rst_i` is still high.
